task_batch_buffer: RTL and testbench
====================================

Name: task_batch_buffer

Overview:
- Input-side counterpart of the result batch buffer.
- Fetches one task batch from the host as 2^TBB_WR_ADDR_WIDTH wide lines, using a line-request/ack handshake, and stores it in a simple dual-port BRAM.
- Exposes the stored batch to a PE array as 32-bit words, readable by word address.
- Sits between the host read-response path and one PE Array; one instance per PE Array.

Parameters:
- TBB_WR_ADDR_WIDTH, 8, line index width; NUM_LINES = 2^8.
- TBB_WR_DATA_WIDTH, 512, host line width.
- TBB_RD_ADDR_WIDTH, 12, PE word address width; must equal TBB_WR_ADDR_WIDTH+4.
- TBB_RD_DATA_WIDTH, 32, PE word width; TBB_WR_DATA_WIDTH = 16*TBB_RD_DATA_WIDTH.

Ports:
- clk  in  1  core clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- fill_start  in  1  request to load a new batch; honoured only in IDLE.
- ReqValid  out  1  buffer requests line ReqLineIdx.
- ReqLineIdx  out  TBB_WR_ADDR_WIDTH  index of the line requested.
- ReqAck  in  1  host delivers ReqData for ReqLineIdx this cycle.
- ReqData  in  TBB_WR_DATA_WIDTH  line payload.
- Full  out  1  batch resident, PE may read.
- Empty  out  1  no valid batch (IDLE or FILL).
- batch_ready  out  1  one-cycle pulse on entry to READY.
- RdEn  in  1  PE word read strobe.
- RdAddr  in  TBB_RD_ADDR_WIDTH  word address.
- RdDout  out  TBB_RD_DATA_WIDTH  read word.
- RdValid  out  1  RdDout valid.
- task_done  in  1  PE finished with the batch; releases the buffer.

Behaviour:
- States, one-hot: IDLE=3'b001, FILL=3'b010, READY=3'b100. Illegal state goes to IDLE next cycle.
- Reset values:
  - state=IDLE, wr_counter=0.
  - ReqValid=0, ReqLineIdx=0, Full=0, Empty=1.
  - batch_ready=0, RdValid=0, RdDout=0.
  - BRAM contents are not cleared.
- IDLE:
  - fill_start=1 -> FILL next cycle, wr_counter=0.
  - task_done, RdEn and ReqAck are ignored.
- FILL:
  - ReqValid=1 and ReqLineIdx=wr_counter, both decoded from registered state (no combinational path from ReqAck).
  - On ReqAck: BRAM we=1, waddr=wr_counter, din=ReqData in the same cycle; wr_counter increments.
  - ReqAck with wr_counter==NUM_LINES-1: wr_counter wraps to 0, state goes to READY.
  - ReqValid holds until acked; the host may stall indefinitely.
  - fill_start and task_done are ignored.
- READY:
  - Full=1, Empty=0.
  - batch_ready=1 in the first READY cycle only.
  - task_done=1 -> IDLE next cycle; Full drops that next cycle.
- Read path:
  - Cycle 0: RdEn sampled with RdAddr, which is split into line = RdAddr[11:4] and word = RdAddr[3:0]. BRAM raddr = line.
  - Cycle 1: BRAM dout is available and the word index is pipelined alongside it.
  - Cycle 2: RdDout and RdValid are registered.
  - Latency is exactly 2 cycles. Throughput is one word per cycle with back-to-back RdEn.
  - RdEn outside READY: RdValid stays 0 for that request and RdDout holds its last value.
- Word ordering within a line: word k = ReqData[512-32k-1 : 512-32k-32], so word 0 is the MSB slice. This matches the write-side packing of the result batch buffer.
- Reads in flight when task_done arrives still complete. Only the RdEn qualification uses the state.
- Simultaneous fill_start and task_done in READY: task_done wins. fill_start is not latched and must be reasserted in IDLE.
- Reset mid-FILL: abort, wr_counter=0, state IDLE. Partial batch is discarded; Empty=1.
- RdValid is 0 whenever RdDout is not from a READY-qualified read.

Decomposition:
- Shared package tbb_pkg holds:
  - state encodings IDLE/FILL/READY;
  - NUM_LINES and WORDS_PER_LINE=16;
  - the address-split helper constants (line and word field widths).
- BRAM is the existing nlb_gram_sdp, configured with BUS_SIZE_ADDR=TBB_WR_ADDR_WIDTH, BUS_SIZE_DATA=TBB_WR_DATA_WIDTH and 1-cycle registered read.
- One natural sub-module: tbb_word_sel, the registered 16:1 word mux producing RdDout/RdValid.

Test Plan:
1. Reset, then fill_start=1 -> next cycle ReqValid=1, ReqLineIdx=0, Empty=1, Full=0.
2. Ack lines 0..255 back-to-back with ReqData[511:480]=line idx, other words = {idx,word#} -> after ack 255: Full=1, batch_ready pulses exactly 1 cycle, ReqValid=0.
3. Random stalls of 0–5 cycles between acks -> ReqLineIdx steady while unacked, exactly 256 BRAM writes, each at the correct index.
4. In READY, RdEn at addresses 0x000, 0x00F, 0x010 and 0xFFF back-to-back -> RdValid high 2 cycles after each; RdDout = line0 word0, line0 word15, line1 word0, line255 word15.
5. RdEn in IDLE and FILL -> RdValid stays 0. task_done in FILL -> ignored, fill continues to completion.
6. reset asserted after 100 acks -> IDLE, ReqValid=0, Empty=1. A new fill_start restarts from ReqLineIdx=0. task_done with fill_start in READY -> IDLE, no new fill begins.

Source files
------------

// File: rtl/tbb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tbb_pkg
// Brief  : Shared encodings and address-split constants for task_batch_buffer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package tbb_pkg;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_FILL  = 3'b010;
    localparam logic [2:0] ST_READY = 3'b100;

    localparam int LINE_FIELD_W   = 8;
    localparam int WORD_FIELD_W   = 4;
    localparam int NUM_LINES      = 1 << LINE_FIELD_W;
    localparam int WORDS_PER_LINE = 1 << WORD_FIELD_W;

endpackage
`default_nettype wire

// File: rtl/nlb_gram_sdp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : nlb_gram_sdp
// Brief  : Simple dual-port block RAM, one write port, registered read port.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module nlb_gram_sdp #(
    parameter int BUS_SIZE_ADDR = 8,
    parameter int BUS_SIZE_DATA = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BUS_SIZE_ADDR-1:0] waddr,
    input  logic [BUS_SIZE_DATA-1:0] din,
    input  logic [BUS_SIZE_ADDR-1:0] raddr,
    output logic [BUS_SIZE_DATA-1:0] dout
);

    logic [BUS_SIZE_DATA-1:0] r_mem [2**BUS_SIZE_ADDR];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
        dout <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/tbb_word_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tbb_word_sel
// Brief  : Registered 16:1 word mux; word 0 is the most significant slice.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tbb_word_sel
    import tbb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINE_W = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_pend,
    input  logic [WORD_FIELD_W-1:0] word_idx,
    input  logic [LINE_W-1:0]       line_data,
    output logic [DATA_W-1:0]       word_out,
    output logic                    word_valid
);

    logic [DATA_W-1:0] w_word;

    always_comb begin
        w_word = '0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            if (word_idx == WORD_FIELD_W'(k)) begin
                w_word = line_data[LINE_W-1-k*DATA_W -: DATA_W];
            end
        end
    end

    // Output word holds its last value when no qualified read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= rd_pend;
            if (rd_pend) begin
                word_out <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/task_batch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : task_batch_buffer
// Brief  : Fetches a task batch line-by-line from the host, serves PE words.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module task_batch_buffer
    import tbb_pkg::*;
#(
    parameter int TBB_WR_ADDR_WIDTH = 8,
    parameter int TBB_WR_DATA_WIDTH = 512,
    parameter int TBB_RD_ADDR_WIDTH = 12,
    parameter int TBB_RD_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fill_start,
    output logic                         ReqValid,
    output logic [TBB_WR_ADDR_WIDTH-1:0] ReqLineIdx,
    input  logic                         ReqAck,
    input  logic [TBB_WR_DATA_WIDTH-1:0] ReqData,
    output logic                         Full,
    output logic                         Empty,
    output logic                         batch_ready,
    input  logic                         RdEn,
    input  logic [TBB_RD_ADDR_WIDTH-1:0] RdAddr,
    output logic [TBB_RD_DATA_WIDTH-1:0] RdDout,
    output logic                         RdValid,
    input  logic                         task_done
);

    localparam logic [TBB_WR_ADDR_WIDTH-1:0] c_last_line = TBB_WR_ADDR_WIDTH'(NUM_LINES - 1);

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [TBB_WR_ADDR_WIDTH-1:0] r_wr_counter;
    logic                         r_batch_ready;
    logic                         w_we;
    logic [TBB_WR_ADDR_WIDTH-1:0] w_raddr;
    logic [TBB_WR_DATA_WIDTH-1:0] w_line;
    logic                         r_rd_pend;
    logic [WORD_FIELD_W-1:0]      r_word_d1;

    assign w_we    = (r_state == ST_FILL) && ReqAck;
    assign w_raddr = RdAddr[TBB_RD_ADDR_WIDTH-1 -: TBB_WR_ADDR_WIDTH];

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = fill_start ? ST_FILL : ST_IDLE;
            ST_FILL:  w_state_nxt = (ReqAck && (r_wr_counter == c_last_line)) ? ST_READY : ST_FILL;
            ST_READY: w_state_nxt = task_done ? ST_IDLE : ST_READY;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wr_counter  <= '0;
            r_batch_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_batch_ready <= (w_state_nxt == ST_READY) && (r_state != ST_READY);
            if ((r_state == ST_IDLE) && fill_start) begin
                r_wr_counter <= '0;
            end else if (w_we) begin
                r_wr_counter <= r_wr_counter + 1'b1;
            end
        end
    end

    // Only the launch of a read is state-qualified; in-flight reads always finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend <= 1'b0;
            r_word_d1 <= '0;
        end else begin
            r_rd_pend <= RdEn && (r_state == ST_READY);
            r_word_d1 <= RdAddr[WORD_FIELD_W-1:0];
        end
    end

    assign ReqValid    = (r_state == ST_FILL);
    assign ReqLineIdx  = r_wr_counter;
    assign Full        = (r_state == ST_READY);
    assign Empty       = ~Full;
    assign batch_ready = r_batch_ready;

    nlb_gram_sdp #(
        .BUS_SIZE_ADDR (TBB_WR_ADDR_WIDTH),
        .BUS_SIZE_DATA (TBB_WR_DATA_WIDTH)
    ) u_gram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_counter),
        .din   (ReqData),
        .raddr (w_raddr),
        .dout  (w_line)
    );

    tbb_word_sel #(
        .DATA_W (TBB_RD_DATA_WIDTH),
        .LINE_W (TBB_WR_DATA_WIDTH)
    ) u_word_sel (
        .clk        (clk),
        .reset      (reset),
        .rd_pend    (r_rd_pend),
        .word_idx   (r_word_d1),
        .line_data  (w_line),
        .word_out   (RdDout),
        .word_valid (RdValid)
    );

endmodule
`default_nettype wire

// File: tb/tb_task_batch_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_task_batch_buffer
// Brief  : Directed self-checking bench for task_batch_buffer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_task_batch_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         fill_start;
    logic         ReqValid;
    logic [7:0]   ReqLineIdx;
    logic         ReqAck;
    logic [511:0] ReqData;
    logic         Full;
    logic         Empty;
    logic         batch_ready;
    logic         RdEn;
    logic [11:0]  RdAddr;
    logic [31:0]  RdDout;
    logic         RdValid;
    logic         task_done;

    int checks = 0;
    int errors = 0;
    int acks   = 0;

    always #5 clk = ~clk;

    task_batch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .fill_start  (fill_start),
        .ReqValid    (ReqValid),
        .ReqLineIdx  (ReqLineIdx),
        .ReqAck      (ReqAck),
        .ReqData     (ReqData),
        .Full        (Full),
        .Empty       (Empty),
        .batch_ready (batch_ready),
        .RdEn        (RdEn),
        .RdAddr      (RdAddr),
        .RdDout      (RdDout),
        .RdValid     (RdValid),
        .task_done   (task_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word 0 carries the line index; other words are {idx, word#}; inv flips all bits.
    function automatic logic [31:0] exp_word(input int line, input int k, input bit inv);
        logic [31:0] w;
        w = (k == 0) ? 32'(line) : {16'(line), 16'(k)};
        return inv ? ~w : w;
    endfunction

    function automatic logic [511:0] mk_line(input int line, input bit inv);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) begin
            l[511-32*k -: 32] = exp_word(line, k, inv);
        end
        return l;
    endfunction

    task automatic do_fill(input int n_lines, input bit inv, input bit stalls, input bit noise);
        for (int i = 0; i < n_lines; i++) begin
            int st;
            st = stalls ? int'($urandom_range(5, 0)) : 0;
            for (int s = 0; s < st; s++) begin
                ReqAck = 1'b0;
                tick();
                chk("stall_idx", 32'(ReqLineIdx), 32'(i));
                chk("stall_valid", 32'(ReqValid), 32'd1);
            end
            chk("fill_idx", 32'(ReqLineIdx), 32'(i));
            chk("fill_valid", 32'(ReqValid), 32'd1);
            chk("fill_rdvalid", 32'(RdValid), 32'd0);
            ReqAck  = 1'b1;
            ReqData = mk_line(i, inv);
            if (noise) begin
                task_done  = i[0];
                fill_start = ~i[0];
                RdEn       = 1'b1;
                RdAddr     = 12'(i * 16);
            end
            if (ReqValid) acks++;
            tick();
            ReqAck     = 1'b0;
            task_done  = 1'b0;
            fill_start = 1'b0;
            RdEn       = 1'b0;
        end
    endtask

    task automatic read_all(input bit inv);
        for (int a = 0; a <= 4096; a++) begin
            RdEn   = (a < 4096);
            RdAddr = 12'(a);
            tick();
            if (a >= 1) begin
                chk("sweep_valid", 32'(RdValid), 32'd1);
                chk("sweep_data", RdDout, exp_word((a - 1) >> 4, (a - 1) & 15, inv));
            end
        end
        RdEn = 1'b0;
        tick();
        chk("sweep_tail_valid", 32'(RdValid), 32'd0);
    endtask

    logic [11:0] dir_addr [4];
    logic [31:0] dir_exp  [4];

    initial begin
        reset = 1'b1; fill_start = 1'b0; ReqAck = 1'b0; ReqData = '0;
        RdEn = 1'b0; RdAddr = '0; task_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_reqvalid", 32'(ReqValid), 32'd0);
        chk("rst_lineidx", 32'(ReqLineIdx), 32'd0);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_batch_ready", 32'(batch_ready), 32'd0);
        chk("rst_rdvalid", 32'(RdValid), 32'd0);
        chk("rst_rddout", RdDout, 32'd0);

        // Reads and task_done in IDLE are ignored
        RdEn = 1'b1; RdAddr = 12'h123; task_done = 1'b1; ReqAck = 1'b1;
        tick(); tick();
        chk("idle_rdvalid", 32'(RdValid), 32'd0);
        chk("idle_reqvalid", 32'(ReqValid), 32'd0);
        RdEn = 1'b0; task_done = 1'b0; ReqAck = 1'b0;
        tick();
        chk("idle_rdvalid2", 32'(RdValid), 32'd0);

        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        chk("start_reqvalid", 32'(ReqValid), 32'd1);
        chk("start_lineidx", 32'(ReqLineIdx), 32'd0);
        chk("start_empty", 32'(Empty), 32'd1);
        chk("start_full", 32'(Full), 32'd0);

        acks = 0;
        do_fill(256, 1'b0, 1'b0, 1'b1);
        chk("fill1_acks", 32'(acks), 32'd256);
        chk("fill1_full", 32'(Full), 32'd1);
        chk("fill1_empty", 32'(Empty), 32'd0);
        chk("fill1_batch_ready", 32'(batch_ready), 32'd1);
        chk("fill1_reqvalid", 32'(ReqValid), 32'd0);
        chk("fill1_lineidx_wrap", 32'(ReqLineIdx), 32'd0);
        tick();
        chk("fill1_batch_ready_drop", 32'(batch_ready), 32'd0);
        chk("fill1_full_hold", 32'(Full), 32'd1);

        // Directed boundary reads, back to back
        dir_addr[0] = 12'h000; dir_exp[0] = 32'h0000_0000;
        dir_addr[1] = 12'h00F; dir_exp[1] = 32'h0000_000F;
        dir_addr[2] = 12'h010; dir_exp[2] = 32'h0000_0001;
        dir_addr[3] = 12'hFFF; dir_exp[3] = 32'h00FF_000F;
        for (int i = 0; i <= 5; i++) begin
            RdEn   = (i < 4);
            RdAddr = (i < 4) ? dir_addr[i] : 12'h0;
            tick();
            if (i == 0) begin
                chk("dir_lat_valid", 32'(RdValid), 32'd0);
            end else if (i <= 4) begin
                chk("dir_valid", 32'(RdValid), 32'd1);
                chk("dir_data", RdDout, dir_exp[i-1]);
            end else begin
                chk("dir_tail_valid", 32'(RdValid), 32'd0);
            end
        end

        read_all(1'b0);

        // Read issued with task_done still completes after release
        RdEn = 1'b1; RdAddr = 12'h123; task_done = 1'b1;
        tick();
        RdEn = 1'b0; task_done = 1'b0;
        chk("done_full", 32'(Full), 32'd0);
        chk("done_empty", 32'(Empty), 32'd1);
        tick();
        chk("inflight_valid", 32'(RdValid), 32'd1);
        chk("inflight_data", RdDout, 32'h0012_0003);
        RdEn = 1'b1; RdAddr = 12'h456;
        tick();
        RdEn = 1'b0;
        tick();
        chk("idle2_rdvalid", 32'(RdValid), 32'd0);
        chk("idle2_rddout_hold", RdDout, 32'h0012_0003);

        // Second fill with random stalls and a distinct pattern
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        acks = 0;
        do_fill(256, 1'b1, 1'b1, 1'b0);
        chk("fill2_acks", 32'(acks), 32'd256);
        chk("fill2_full", 32'(Full), 32'd1);
        chk("fill2_batch_ready", 32'(batch_ready), 32'd1);
        read_all(1'b1);

        // task_done beats fill_start in READY, and fill_start is not latched
        task_done = 1'b1; fill_start = 1'b1;
        tick();
        task_done = 1'b0; fill_start = 1'b0;
        chk("tie_full", 32'(Full), 32'd0);
        chk("tie_reqvalid", 32'(ReqValid), 32'd0);
        tick();
        chk("tie_no_fill", 32'(ReqValid), 32'd0);
        chk("tie_empty", 32'(Empty), 32'd1);

        // Reset mid-fill aborts, next fill restarts at line 0
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        do_fill(100, 1'b0, 1'b0, 1'b0);
        chk("mid_lineidx", 32'(ReqLineIdx), 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_reqvalid", 32'(ReqValid), 32'd0);
        chk("abort_empty", 32'(Empty), 32'd1);
        chk("abort_full", 32'(Full), 32'd0);
        chk("abort_lineidx", 32'(ReqLineIdx), 32'd0);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        chk("restart_reqvalid", 32'(ReqValid), 32'd1);
        chk("restart_lineidx", 32'(ReqLineIdx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
